// File: rtl/hpm_pkg.sv
// Shared constants and CSR decode helper for the EXU hardware performance monitor.
// Holds the machine-mode HPM CSR base addresses and the mhpmevent field positions.
package hpm_pkg;

  localparam logic [11:0] HPM_CNT_LO_BASE = 12'hB03;
  localparam logic [11:0] HPM_CNT_HI_BASE = 12'hB83;
  localparam logic [11:0] HPM_EVT_BASE    = 12'h323;
  localparam logic [11:0] HPM_INHIBIT     = 12'h320;

  localparam int EVT_SEL_MSB  = 7;
  localparam int EVT_OFIE_BIT = 30;
  localparam int EVT_OF_BIT   = 31;

  typedef enum logic [1:0] {
    HPM_ACC_NONE,
    HPM_ACC_LO,
    HPM_ACC_HI,
    HPM_ACC_EVT
  } hpm_acc_e;

  // Classifies which per-counter register of the given slot a CSR index selects.
  function automatic hpm_acc_e hpm_decode(input logic [11:0] idx, input int unsigned slot);
    logic [11:0] off;
    off = 12'(slot);
    if (idx == HPM_CNT_LO_BASE + off) return HPM_ACC_LO;
    if (idx == HPM_CNT_HI_BASE + off) return HPM_ACC_HI;
    if (idx == HPM_EVT_BASE + off)    return HPM_ACC_EVT;
    return HPM_ACC_NONE;
  endfunction

endpackage

// File: rtl/hpm_counter.sv
// One HPM counter slice: count, event selector, sticky overflow flag and its enable.
// Resolves same-edge software writes against hardware increments and overflow.
module hpm_counter
  import hpm_pkg::*;
#(
  parameter int CNT_W   = 64,
  parameter int NUM_EVT = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_lo_i,
  input  logic               wr_hi_i,
  input  logic               wr_evt_i,
  input  logic [31:0]        wdat_i,
  input  logic [NUM_EVT-1:0] evt_q_i,
  input  logic               inhibit_i,
  output logic [31:0]        cnt_lo_o,
  output logic [31:0]        cnt_hi_o,
  output logic [31:0]        evt_cfg_o,
  output logic               of_irq_o
);

  localparam int SEL_W = EVT_SEL_MSB + 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic             of_q, of_d;
  logic             ofie_q, ofie_d;
  logic             inc;
  logic             wrap;

  // Selectors of 0 or beyond NUM_EVT never match any event line.
  always_comb begin
    inc = 1'b0;
    for (int k = 0; k < NUM_EVT; k++) begin
      if (sel_q == SEL_W'(k + 1) && evt_q_i[k]) inc = 1'b1;
    end
    inc = inc & ~inhibit_i;
  end

  always_comb begin
    cnt_d  = cnt_q;
    sel_d  = sel_q;
    of_d   = of_q;
    ofie_d = ofie_q;
    wrap   = 1'b0;
    if (wr_lo_i) begin
      cnt_d[31:0] = wdat_i;
    end else if (wr_hi_i) begin
      // Low half keeps counting; its carry is lost under the high-half write.
      cnt_d[CNT_W-1:32] = wdat_i[CNT_W-33:0];
      if (inc) cnt_d[31:0] = cnt_q[31:0] + 32'd1;
    end else if (inc) begin
      cnt_d = cnt_q + CNT_W'(1);
      wrap  = &cnt_q;
    end
    if (wr_evt_i) begin
      sel_d  = wdat_i[EVT_SEL_MSB:0];
      ofie_d = wdat_i[EVT_OFIE_BIT];
      of_d   = wdat_i[EVT_OF_BIT];
    end
    if (wrap) of_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      sel_q  <= '0;
      of_q   <= 1'b0;
      ofie_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      sel_q  <= sel_d;
      of_q   <= of_d;
      ofie_q <= ofie_d;
    end
  end

  always_comb begin
    evt_cfg_o                  = '0;
    evt_cfg_o[EVT_SEL_MSB:0]   = sel_q;
    evt_cfg_o[EVT_OFIE_BIT]    = ofie_q;
    evt_cfg_o[EVT_OF_BIT]      = of_q;
  end

  assign cnt_lo_o = cnt_q[31:0];
  assign cnt_hi_o = 32'(cnt_q[CNT_W-1:32]);
  assign of_irq_o = of_q & ofie_q;

endmodule

// File: rtl/exu_hpm.sv
// Machine-mode HPM bank beside the core CSR unit: decode, event register,
// mcountinhibit, combinational read mux and the registered overflow interrupt.
module exu_hpm
  import hpm_pkg::*;
#(
  parameter int NUM_CNT = 4,
  parameter int CNT_W   = 64,
  parameter int NUM_EVT = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               csr_wen,
  input  logic               csr_ren,
  input  logic [11:0]        csr_idx,
  input  logic [31:0]        csr_wdat,
  output logic [31:0]        csr_rdat,
  output logic               csr_hit,
  input  logic [NUM_EVT-1:0] evt_i,
  output logic               ovf_irq
);

  logic [NUM_EVT-1:0] evt_q;
  logic [NUM_CNT-1:0] inh_q, inh_d;
  logic               ovf_irq_q;
  logic               inh_hit;
  logic [31:0]        rd_mux;

  hpm_acc_e           acc [NUM_CNT];
  logic [NUM_CNT-1:0] wr_lo, wr_hi, wr_evt, of_irq;
  logic [31:0]        cnt_lo  [NUM_CNT];
  logic [31:0]        cnt_hi  [NUM_CNT];
  logic [31:0]        evt_cfg [NUM_CNT];

  // Decode and read mux; hit is independent of the strobes, data gated by ren.
  always_comb begin
    inh_hit = (csr_idx == HPM_INHIBIT);
    csr_hit = inh_hit;
    rd_mux  = inh_hit ? (32'(inh_q) << 3) : 32'd0;
    for (int i = 0; i < NUM_CNT; i++) begin
      acc[i]    = hpm_decode(csr_idx, i);
      wr_lo[i]  = csr_wen && (acc[i] == HPM_ACC_LO);
      wr_hi[i]  = csr_wen && (acc[i] == HPM_ACC_HI);
      wr_evt[i] = csr_wen && (acc[i] == HPM_ACC_EVT);
      case (acc[i])
        HPM_ACC_LO:  begin csr_hit = 1'b1; rd_mux = cnt_lo[i];  end
        HPM_ACC_HI:  begin csr_hit = 1'b1; rd_mux = cnt_hi[i];  end
        HPM_ACC_EVT: begin csr_hit = 1'b1; rd_mux = evt_cfg[i]; end
        default: ;
      endcase
    end
    csr_rdat = csr_ren ? rd_mux : 32'd0;
  end

  always_comb begin
    inh_d = inh_q;
    if (csr_wen && inh_hit) inh_d = csr_wdat[3 +: NUM_CNT];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      evt_q     <= '0;
      inh_q     <= '0;
      ovf_irq_q <= 1'b0;
    end else begin
      evt_q     <= evt_i;
      inh_q     <= inh_d;
      ovf_irq_q <= |of_irq;
    end
  end

  assign ovf_irq = ovf_irq_q;

  for (genvar i = 0; i < NUM_CNT; i++) begin : g_cnt
    hpm_counter #(
      .CNT_W  (CNT_W),
      .NUM_EVT(NUM_EVT)
    ) u_cnt (
      .clk      (clk),
      .rst      (rst),
      .wr_lo_i  (wr_lo[i]),
      .wr_hi_i  (wr_hi[i]),
      .wr_evt_i (wr_evt[i]),
      .wdat_i   (csr_wdat),
      .evt_q_i  (evt_q),
      .inhibit_i(inh_q[i]),
      .cnt_lo_o (cnt_lo[i]),
      .cnt_hi_o (cnt_hi[i]),
      .evt_cfg_o(evt_cfg[i]),
      .of_irq_o (of_irq[i])
    );
  end

endmodule

// File: tb/tb_exu_hpm.sv
// Self-checking bench for exu_hpm: directed steps plus randomized CSR/event traffic
// checked against a counter-level behavioural model; a 40-bit instance covers the narrow width.
module tb_exu_hpm;

  logic        clk;
  logic        rst;
  logic        csr_wen, csr_ren;
  logic [11:0] csr_idx;
  logic [31:0] csr_wdat, csr_rdat;
  logic        csr_hit;
  logic [7:0]  evt_i;
  logic        ovf_irq;

  logic        b40Wen, b40Ren;
  logic [11:0] b40Idx;
  logic [31:0] b40Wdat, b40Rdat;
  logic        b40Hit;
  logic [7:0]  b40Evt;
  logic        b40Irq;

  int compared;
  int mismatched;

  logic [31:0] lastRdat;
  logic        lastHit;
  logic        lastIrq;
  logic [31:0] last40;
  logic        last40Hit;

  longint unsigned mCnt [4];
  logic [7:0]      mSel [4];
  logic            mOf [4];
  logic            mOfie [4];
  logic            mInh [4];
  logic [7:0]      mEvtQ;
  logic            mIrq;

  exu_hpm dut (
    .clk(clk), .rst(rst), .csr_wen(csr_wen), .csr_ren(csr_ren), .csr_idx(csr_idx),
    .csr_wdat(csr_wdat), .csr_rdat(csr_rdat), .csr_hit(csr_hit), .evt_i(evt_i),
    .ovf_irq(ovf_irq)
  );

  exu_hpm #(.NUM_CNT(4), .CNT_W(40), .NUM_EVT(8)) dut40 (
    .clk(clk), .rst(rst), .csr_wen(b40Wen), .csr_ren(b40Ren), .csr_idx(b40Idx),
    .csr_wdat(b40Wdat), .csr_rdat(b40Rdat), .csr_hit(b40Hit), .evt_i(b40Evt),
    .ovf_irq(b40Irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  function automatic void modelReset();
    for (int i = 0; i < 4; i++) begin
      mCnt[i] = 0; mSel[i] = 0; mOf[i] = 0; mOfie[i] = 0; mInh[i] = 0;
    end
    mEvtQ = 0;
    mIrq  = 0;
  endfunction

  function automatic logic modelHit(input logic [11:0] idx);
    if (idx == 12'h320) return 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (idx == 12'(12'hB03 + i) || idx == 12'(12'hB83 + i) || idx == 12'(12'h323 + i)) return 1'b1;
    end
    return 1'b0;
  endfunction

  function automatic logic [31:0] modelRead(input logic [11:0] idx, input logic ren);
    logic [31:0] r;
    r = 32'd0;
    if (!ren) return r;
    if (idx == 12'h320) r = {25'd0, mInh[3], mInh[2], mInh[1], mInh[0], 3'd0};
    for (int i = 0; i < 4; i++) begin
      if (idx == 12'(12'hB03 + i)) r = 32'(mCnt[i]);
      if (idx == 12'(12'hB83 + i)) r = 32'(mCnt[i] >> 32);
      if (idx == 12'(12'h323 + i)) r = {mOf[i], mOfie[i], 22'd0, mSel[i]};
    end
    return r;
  endfunction

  // Advances the model by one clock edge using the inputs present before that edge.
  function automatic void modelStep(input logic wen, input logic [11:0] idx, input logic [31:0] wdat,
                                    input logic [7:0] evt, input logic rstIn);
    logic inc [4];
    logic irqNext;
    logic ovf;
    if (rstIn) begin
      modelReset();
      return;
    end
    irqNext = 1'b0;
    for (int i = 0; i < 4; i++) begin
      irqNext = irqNext | (mOf[i] & mOfie[i]);
      inc[i] = (mSel[i] >= 8'd1) && (mSel[i] <= 8'd8) && !mInh[i] && mEvtQ[mSel[i] - 8'd1];
    end
    for (int i = 0; i < 4; i++) begin
      ovf = 1'b0;
      if (wen && idx == 12'(12'hB03 + i)) begin
        mCnt[i] = (mCnt[i] & 64'hFFFF_FFFF_0000_0000) | longint'(wdat);
      end else if (wen && idx == 12'(12'hB83 + i)) begin
        mCnt[i] = (longint'(wdat) << 32) | ((mCnt[i] + (inc[i] ? 1 : 0)) & 64'h0000_0000_FFFF_FFFF);
      end else if (inc[i]) begin
        if (mCnt[i] == 64'hFFFF_FFFF_FFFF_FFFF) ovf = 1'b1;
        mCnt[i] = mCnt[i] + 1;
      end
      if (wen && idx == 12'(12'h323 + i)) begin
        mSel[i] = wdat[7:0]; mOfie[i] = wdat[30]; mOf[i] = wdat[31];
      end
      if (ovf) mOf[i] = 1'b1;
      if (wen && idx == 12'h320) mInh[i] = wdat[3 + i];
    end
    mEvtQ = evt;
    mIrq  = irqNext;
  endfunction

  // One clock of traffic on the main instance; outputs checked mid-cycle against the model.
  task automatic applyStimulus(input logic wen, input logic ren, input logic [11:0] idx,
                               input logic [31:0] wdat, input logic [7:0] evt, input logic rstIn);
    csr_wen = wen; csr_ren = ren; csr_idx = idx; csr_wdat = wdat; evt_i = evt; rst = rstIn;
    #4;
    lastRdat = csr_rdat; lastHit = csr_hit; lastIrq = ovf_irq;
    checkOutput($sformatf("rdat idx=%h", idx), csr_rdat, modelRead(idx, ren));
    checkOutput($sformatf("hit idx=%h", idx), {31'd0, csr_hit}, {31'd0, modelHit(idx)});
    checkOutput("ovf_irq", {31'd0, ovf_irq}, {31'd0, mIrq});
    @(posedge clk);
    modelStep(wen, idx, wdat, evt, rstIn);
    #1;
  endtask

  task automatic writeCsr(input logic [11:0] idx, input logic [31:0] wdat);
    applyStimulus(1'b1, 1'b0, idx, wdat, 8'h00, 1'b0);
  endtask

  task automatic readCsr(input logic [11:0] idx);
    applyStimulus(1'b0, 1'b1, idx, 32'd0, 8'h00, 1'b0);
  endtask

  task automatic pulse(input logic [7:0] evt);
    applyStimulus(1'b0, 1'b0, 12'h000, 32'd0, evt, 1'b0);
  endtask

  // One clock on the 40-bit instance while the main instance idles.
  task automatic dut40Cycle(input logic wen, input logic ren, input logic [11:0] idx,
                            input logic [31:0] wdat, input logic [7:0] evt);
    csr_wen = 1'b0; csr_ren = 1'b0; csr_idx = 12'h000; csr_wdat = 32'd0; evt_i = 8'h00; rst = 1'b0;
    b40Wen = wen; b40Ren = ren; b40Idx = idx; b40Wdat = wdat; b40Evt = evt;
    #4;
    last40 = b40Rdat; last40Hit = b40Hit;
    @(posedge clk);
    modelStep(1'b0, 12'h000, 32'd0, 8'h00, 1'b0);
    #1;
    b40Wen = 1'b0; b40Ren = 1'b0; b40Evt = 8'h00;
  endtask

  logic [11:0] idxPool [16];

  initial begin
    compared = 0; mismatched = 0;
    rst = 1'b1; csr_wen = 0; csr_ren = 0; csr_idx = 0; csr_wdat = 0; evt_i = 0;
    b40Wen = 0; b40Ren = 0; b40Idx = 0; b40Wdat = 0; b40Evt = 0;
    repeat (2) @(posedge clk);
    #1;
    modelReset();

    // Reset state and decode
    readCsr(12'hB03); checkOutput("reset lo", lastRdat, 32'd0); checkOutput("hit lo", {31'd0, lastHit}, 32'd1);
    readCsr(12'hB83); checkOutput("reset hi", lastRdat, 32'd0);
    readCsr(12'h323); checkOutput("reset evt", lastRdat, 32'd0);
    readCsr(12'h320); checkOutput("reset inh", lastRdat, 32'd0); checkOutput("hit inh", {31'd0, lastHit}, 32'd1);
    readCsr(12'hB07); checkOutput("hit unimpl", {31'd0, lastHit}, 32'd0);

    // Basic counting and inhibit
    writeCsr(12'h323, 32'd1);
    repeat (5) pulse(8'h01);
    pulse(8'h00);
    readCsr(12'hB03); checkOutput("count5", lastRdat, 32'd5);
    writeCsr(12'h320, 32'h8);
    repeat (5) pulse(8'h01);
    repeat (2) pulse(8'h00);
    readCsr(12'hB03); checkOutput("inhibited", lastRdat, 32'd5);
    writeCsr(12'h320, 32'h0);

    // Wrap, sticky OF and interrupt
    writeCsr(12'hB03, 32'hFFFF_FFFF);
    writeCsr(12'hB83, 32'hFFFF_FFFF);
    writeCsr(12'h323, 32'h4000_0001);
    pulse(8'h01);
    pulse(8'h00);
    readCsr(12'hB03); checkOutput("wrap lo", lastRdat, 32'd0); checkOutput("irq before", {31'd0, lastIrq}, 32'd0);
    readCsr(12'h323); checkOutput("of set", lastRdat, 32'hC000_0001); checkOutput("irq rise", {31'd0, lastIrq}, 32'd1);
    readCsr(12'hB83); checkOutput("wrap hi", lastRdat, 32'd0);
    writeCsr(12'h323, 32'h4000_0001);
    pulse(8'h00);
    readCsr(12'h323); checkOutput("of cleared", lastRdat, 32'h4000_0001); checkOutput("irq fall", {31'd0, lastIrq}, 32'd0);

    // Same-edge collisions
    writeCsr(12'hB03, 32'h10);
    pulse(8'h01);
    writeCsr(12'hB03, 32'h100);
    readCsr(12'hB03); checkOutput("lo write wins", lastRdat, 32'h100);
    pulse(8'h01);
    writeCsr(12'h320, 32'h8);
    readCsr(12'hB03); checkOutput("old inhibit", lastRdat, 32'h101);
    writeCsr(12'h320, 32'h0);
    writeCsr(12'hB03, 32'hFFFF_FFFF);
    pulse(8'h01);
    writeCsr(12'hB83, 32'h5);
    readCsr(12'hB03); checkOutput("hi write lo inc", lastRdat, 32'd0);
    readCsr(12'hB83); checkOutput("hi write wins", lastRdat, 32'h5);
    readCsr(12'h323); checkOutput("no of on hi write", lastRdat, 32'h4000_0001);

    // 40-bit counter width
    dut40Cycle(1, 0, 12'h323, 32'd1, 8'h00);
    dut40Cycle(1, 0, 12'hB83, 32'hFFFF_FFFF, 8'h00);
    dut40Cycle(0, 1, 12'hB83, 32'd0, 8'h00);
    checkOutput("w40 hi mask", last40, 32'h0000_00FF); checkOutput("w40 hit", {31'd0, last40Hit}, 32'd1);
    dut40Cycle(1, 0, 12'hB83, 32'd0, 8'h00);
    dut40Cycle(1, 0, 12'hB03, 32'hFFFF_FFFF, 8'h00);
    dut40Cycle(0, 0, 12'h000, 32'd0, 8'h01);
    dut40Cycle(0, 0, 12'h000, 32'd0, 8'h00);
    dut40Cycle(0, 1, 12'hB83, 32'd0, 8'h00); checkOutput("w40 carry", last40, 32'd1);
    dut40Cycle(0, 1, 12'hB03, 32'd0, 8'h00); checkOutput("w40 lo", last40, 32'd0);
    dut40Cycle(0, 1, 12'h323, 32'd0, 8'h00); checkOutput("w40 no of", last40, 32'd1);

    // Out-of-range selector, then reset mid-count
    writeCsr(12'hB03, 32'd0);
    writeCsr(12'hB83, 32'd0);
    writeCsr(12'h323, 32'd9);
    repeat (4) pulse(8'hFF);
    pulse(8'h00);
    readCsr(12'hB03); checkOutput("sel9 no count", lastRdat, 32'd0);
    readCsr(12'h323); checkOutput("sel9 readback", lastRdat, 32'd9);
    writeCsr(12'h323, 32'd1);
    writeCsr(12'h320, 32'h10);
    repeat (3) pulse(8'hFF);
    applyStimulus(1'b0, 1'b0, 12'h000, 32'd0, 8'hFF, 1'b1);
    readCsr(12'hB03); checkOutput("rst lo", lastRdat, 32'd0);
    readCsr(12'h323); checkOutput("rst evt", lastRdat, 32'd0);
    readCsr(12'h320); checkOutput("rst inh", lastRdat, 32'd0); checkOutput("rst irq", {31'd0, lastIrq}, 32'd0);

    // Randomized traffic against the model
    idxPool = '{12'hB03, 12'hB04, 12'hB05, 12'hB06, 12'hB83, 12'hB84, 12'hB85, 12'hB86,
                12'h323, 12'h324, 12'h325, 12'h326, 12'h320, 12'hB07, 12'h327, 12'h321};
    for (int n = 0; n < 1500; n++) begin
      logic [31:0] w;
      logic [31:0] r;
      r = $urandom;
      case ($urandom_range(0, 3))
        0: w = $urandom;
        1: w = 32'hFFFF_FFFF;
        2: w = 32'hFFFF_FFFE;
        default: w = {r[31:30], 26'd0, r[3:0]};
      endcase
      applyStimulus(($urandom_range(0, 3) == 0), $urandom_range(0, 1) == 1,
                    idxPool[$urandom_range(0, 15)], w, 8'($urandom),
                    ($urandom_range(0, 299) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
